control_sequencer: RTL

Multi-cycle control unit that generates the one-hot bus-drive strobes and register-load strobes for the 32-bit shared-bus datapath. It sits directly upstream of the bus multiplexer and its encoder. Every `*out` strobe it raises selects the bus source for that cycle, and every `*in` strobe latches the bus into a destination. It sequences fetch (T0–T2) and execute (T3–T7) for a load/store/ALU subset, with a ready handshake to memory.

---
 rtl/control_sequencer_if.sv | 48 ++++
 rtl/control_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/control_sequencer_if.sv
// Bus between the control sequencer and the shared-bus datapath.
//
// Memory handshake: read/write are raised on entry to a memory wait state
// and held until the rising edge that samples mem_ready=1; they drop in the
// state that follows. mem_ready is only looked at while read or write is high.
interface control_sequencer_if;
    logic [31:0] ir;
    logic        mem_ready;
    logic [15:0] reg_out;
    logic [15:0] reg_in;
    logic        PCout;
    logic        Zlowout;
    logic        MDRout;
    logic        Cout;
    logic        HIout;
    logic        LOout;
    logic        Zhighout;
    logic        In_Portout;
    logic        PCin;
    logic        IRin;
    logic        MARin;
    logic        MDRin;
    logic        Yin;
    logic        Zin;
    logic        IncPC;
    logic        read;
    logic        write;
    logic [4:0]  alu_op;
    logic        run;

    // Sequencer side: consumes ir/mem_ready, drives every strobe.
    modport master (
        input  ir, mem_ready,
        output reg_out, reg_in, PCout, Zlowout, MDRout, Cout,
               HIout, LOout, Zhighout, In_Portout,
               PCin, IRin, MARin, MDRin, Yin, Zin, IncPC,
               read, write, alu_op, run
    );

    // Datapath/memory side.
    modport slave (
        output ir, mem_ready,
        input  reg_out, reg_in, PCout, Zlowout, MDRout, Cout,
               HIout, LOout, Zhighout, In_Portout,
               PCin, IRin, MARin, MDRin, Yin, Zin, IncPC,
               read, write, alu_op, run
    );
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle control unit for the 32-bit shared-bus datapath.
// Fetch runs T0..T2, execute T3..T7. All strobes are Moore decodes of the
// current state plus ir fields, so an asynchronous reset of the state
// register clears every output immediately.
module control_sequencer (
    input  logic                       clock,
    input  logic                       reset_n,
    control_sequencer_if.master        bus,
    output logic [3:0]                 dbg_state_o
);
    typedef enum logic [3:0] {
        S_RST  = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_T7   = 4'd8,
        S_HALT = 4'd9
    } state_e;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_HALT = 5'b11011;

    state_e state_q, state_d;

    logic [4:0]  opcode;
    logic [15:0] ra_oh, rb_oh, rc_oh;
    logic        is_alu, is_addi, is_ld, is_st, is_halt, is_mem, has_exec;
    logic        unused_ir_bits;

    // Field extraction and register one-hot decode, purely combinational.
    assign opcode   = bus.ir[31:27];
    assign ra_oh    = 16'b1 << bus.ir[26:23];
    assign rb_oh    = 16'b1 << bus.ir[22:19];
    assign rc_oh    = 16'b1 << bus.ir[18:15];
    assign unused_ir_bits = ^bus.ir[14:0];

    assign is_alu   = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                      (opcode == OP_AND) || (opcode == OP_OR);
    assign is_addi  = (opcode == OP_ADDI);
    assign is_ld    = (opcode == OP_LD);
    assign is_st    = (opcode == OP_ST);
    assign is_halt  = (opcode == OP_HALT);
    assign is_mem   = is_ld || is_st;
    // Anything that is not one of these falls through T3 as a nop.
    assign has_exec = is_alu || is_addi || is_mem;

    // Strobes this block never uses.
    assign bus.HIout      = 1'b0;
    assign bus.LOout      = 1'b0;
    assign bus.Zhighout   = 1'b0;
    assign bus.In_Portout = 1'b0;

    assign dbg_state_o = state_q;

    // State register; reset forces RST, which decodes to all-zero outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= S_RST;
        else          state_q <= state_d;
    end

    // Next-state and Moore strobe decode.
    always_comb begin
        state_d      = state_q;
        bus.reg_out  = '0;
        bus.reg_in   = '0;
        bus.PCout    = 1'b0;
        bus.Zlowout  = 1'b0;
        bus.MDRout   = 1'b0;
        bus.Cout     = 1'b0;
        bus.PCin     = 1'b0;
        bus.IRin     = 1'b0;
        bus.MARin    = 1'b0;
        bus.MDRin    = 1'b0;
        bus.Yin      = 1'b0;
        bus.Zin      = 1'b0;
        bus.IncPC    = 1'b0;
        bus.read     = 1'b0;
        bus.write    = 1'b0;
        bus.alu_op   = '0;
        bus.run      = 1'b0;
        case (state_q)
            S_RST: state_d = S_T0;
            S_T0: begin
                bus.run   = 1'b1;
                bus.PCout = 1'b1;
                bus.MARin = 1'b1;
                bus.IncPC = 1'b1;
                bus.Zin   = 1'b1;
                state_d   = S_T1;
            end
            S_T1: begin
                // Re-latching PC/MDR while stalled is harmless.
                bus.run     = 1'b1;
                bus.Zlowout = 1'b1;
                bus.PCin    = 1'b1;
                bus.read    = 1'b1;
                bus.MDRin   = 1'b1;
                if (bus.mem_ready) state_d = S_T2;
            end
            S_T2: begin
                bus.run    = 1'b1;
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
                state_d    = S_T3;
            end
            S_T3: begin
                bus.run = 1'b1;
                if (is_halt) begin
                    state_d = S_HALT;
                end else if (has_exec) begin
                    bus.reg_out = rb_oh;
                    bus.Yin     = 1'b1;
                    state_d     = S_T4;
                end else begin
                    state_d = S_T0;
                end
            end
            S_T4: begin
                bus.run = 1'b1;
                bus.Zin = 1'b1;
                if (is_alu) begin
                    bus.reg_out = rc_oh;
                    bus.alu_op  = opcode;
                end else begin
                    // addi, ld and st all form Rb + constant.
                    bus.Cout   = 1'b1;
                    bus.alu_op = OP_ADD;
                end
                state_d = S_T5;
            end
            S_T5: begin
                bus.run     = 1'b1;
                bus.Zlowout = 1'b1;
                if (is_mem) begin
                    bus.MARin = 1'b1;
                    state_d   = S_T6;
                end else begin
                    bus.reg_in = ra_oh;
                    state_d    = S_T0;
                end
            end
            S_T6: begin
                bus.run   = 1'b1;
                bus.MDRin = 1'b1;
                if (is_ld) begin
                    bus.read = 1'b1;
                    if (bus.mem_ready) state_d = S_T7;
                end else begin
                    bus.reg_out = ra_oh;
                    state_d     = S_T7;
                end
            end
            S_T7: begin
                bus.run = 1'b1;
                if (is_ld) begin
                    bus.MDRout = 1'b1;
                    bus.reg_in = ra_oh;
                    state_d    = S_T0;
                end else begin
                    bus.write = 1'b1;
                    if (bus.mem_ready) state_d = S_T0;
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_RST;
        endcase
    end
endmodule
